// File: rtl/power_mode_ctrl.sv
// Power button / mode switch front end: synchronise, debounce, long-press power FSM and mode gating.
// Build option AUTO_OFF_EN adds an idle timer that powers the car off after IDLE_OFF_CYCLES at mode 00.
module power_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 2000000,
  parameter int unsigned LONG_PRESS_CYCLES = 100000000,
  parameter int unsigned IDLE_OFF_CYCLES   = 1000000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_btn,
  input  logic [1:0] mode_selection,
  output logic       power_state,
  output logic [1:0] mode,
  output logic       power_on_pulse,
  output logic       power_off_pulse,
  output logic       mode_change
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LP_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_FIRE = LP_W'(LONG_PRESS_CYCLES - 2);

  // The release-seen argument relies on the debounce window outlasting the 2-FF synchroniser.
  if (DEBOUNCE_CYCLES < 3 || LONG_PRESS_CYCLES < 2 || IDLE_OFF_CYCLES < 2) begin : g_bad_cfg
    $error("power_mode_ctrl: counter parameters too small");
  end

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_ARMING   = 3'd1,
    S_ON_HOLD  = 3'd2,
    S_ON       = 3'd3,
    S_OFF_HOLD = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            btn_s1, btn_s2;
  logic [1:0]      sel_s1, sel_s2;
  logic [DB_W-1:0] db_cnt, rel_cnt;
  logic            db_level, seen_rel;
  logic [LP_W-1:0] lp_cnt;
  logic            lp_clr;
  logic            power_n, on_pulse_n, off_pulse_n;
  logic            idle_fire_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sel_s1 <= 2'b00;
      sel_s2 <= 2'b00;
    end else begin
      btn_s1 <= power_btn;
      btn_s2 <= btn_s1;
      sel_s1 <= mode_selection;
      sel_s2 <= sel_s1;
    end
  end

  // Debounce, plus a release qualifier so a press held through reset cannot arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      rel_cnt  <= '0;
      seen_rel <= 1'b0;
    end else begin
      if (btn_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end

      if (btn_s2) begin
        rel_cnt <= '0;
      end else if (!seen_rel) begin
        if (rel_cnt == DB_LAST) seen_rel <= 1'b1;
        else                    rel_cnt  <= rel_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              lp_cnt <= '0;
    else if (lp_clr)                                       lp_cnt <= '0;
    else if (state == S_ARMING && db_level && lp_cnt != LP_LAST) lp_cnt <= lp_cnt + LP_W'(1);
  end

`ifdef AUTO_OFF_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_OFF_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_OFF_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_FIRE = IDLE_W'(IDLE_OFF_CYCLES - 2);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_run_c;

  assign idle_run_c = (state == S_ON || state == S_ON_HOLD) && mode == 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       idle_cnt <= '0;
    else if (!idle_run_c)           idle_cnt <= '0;
    else if (idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  // Fires on the edge where the idle count reaches IDLE_OFF_CYCLES-1.
  assign idle_fire_c = idle_run_c && idle_cnt == IDLE_FIRE;
`else
  assign idle_fire_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_OFF;
    else      state <= state_n;
  end

  // Long press fires on the edge where the press count reaches LONG_PRESS_CYCLES-1.
  always_comb begin
    state_n     = state;
    power_n     = power_state;
    on_pulse_n  = 1'b0;
    off_pulse_n = 1'b0;
    lp_clr      = 1'b0;
    case (state)
      S_OFF: begin
        power_n = 1'b0;
        if (db_level && seen_rel) begin
          state_n = S_ARMING;
          lp_clr  = 1'b1;
        end
      end
      S_ARMING: begin
        power_n = 1'b0;
        if (!db_level) begin
          state_n = S_OFF;
        end else if (lp_cnt == LP_FIRE) begin
          state_n    = S_ON_HOLD;
          power_n    = 1'b1;
          on_pulse_n = 1'b1;
        end
      end
      S_ON_HOLD: begin
        power_n = 1'b1;
        if (idle_fire_c) begin
          state_n     = S_OFF_HOLD;
          power_n     = 1'b0;
          off_pulse_n = 1'b1;
        end else if (!db_level) begin
          state_n = S_ON;
        end
      end
      S_ON: begin
        power_n = 1'b1;
        if (db_level) begin
          state_n     = S_OFF_HOLD;
          power_n     = 1'b0;
          off_pulse_n = 1'b1;
        end else if (idle_fire_c) begin
          state_n     = S_OFF;
          power_n     = 1'b0;
          off_pulse_n = 1'b1;
        end
      end
      S_OFF_HOLD: begin
        power_n = 1'b0;
        if (!db_level) state_n = S_OFF;
      end
      default: begin
        state_n = S_OFF;
        power_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      power_state     <= 1'b0;
      power_on_pulse  <= 1'b0;
      power_off_pulse <= 1'b0;
    end else begin
      power_state     <= power_n;
      power_on_pulse  <= on_pulse_n;
      power_off_pulse <= off_pulse_n;
    end
  end

  // Mode tracks the selection only while powered before and after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode        <= 2'b00;
      mode_change <= 1'b0;
    end else if (power_state && power_n) begin
      mode        <= sel_s2;
      mode_change <= (sel_s2 != mode);
    end else begin
      mode        <= 2'b00;
      mode_change <= 1'b0;
    end
  end

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Directed-plus-random bench for power_mode_ctrl against an event-level reference model.
module tb_power_mode_ctrl;

  localparam int unsigned DB   = 4;
  localparam int unsigned LP   = 20;
  localparam int unsigned IDLE = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       power_btn = 1'b0;
  logic [1:0] mode_selection = 2'b00;
  logic       power_state;
  logic [1:0] mode;
  logic       power_on_pulse;
  logic       power_off_pulse;
  logic       mode_change;

  int total = 0;
  int bad   = 0;

  power_mode_ctrl #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .IDLE_OFF_CYCLES  (IDLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .power_btn      (power_btn),
    .mode_selection (mode_selection),
    .power_state    (power_state),
    .mode           (mode),
    .power_on_pulse (power_on_pulse),
    .power_off_pulse(power_off_pulse),
    .mode_change    (mode_change)
  );

  always #5 clk = ~clk;

  // Reference model: pin delay lines, a sample window for debounce, press-length counting.
  bit       m_bd [2];
  bit [1:0] m_sd [2];
  bit       m_win [$];
  bit       m_lvl, m_seen, m_need, m_pw, m_onp, m_offp, m_mc;
  bit [1:0] m_mode;
  int       m_held;
`ifdef AUTO_OFF_EN
  int       m_idle;
`endif

  task automatic model_reset();
    m_bd[0] = 1'b0; m_bd[1] = 1'b0;
    m_sd[0] = 2'b00; m_sd[1] = 2'b00;
    m_win.delete();
    m_lvl = 1'b0; m_seen = 1'b0; m_need = 1'b1;
    m_pw = 1'b0; m_onp = 1'b0; m_offp = 1'b0; m_mc = 1'b0;
    m_mode = 2'b00; m_held = 0;
`ifdef AUTO_OFF_EN
    m_idle = 0;
`endif
  endtask

  task automatic model_edge(input bit p, input bit [1:0] sel);
    bit       sb, l, seen_o, pw_o, pw_n, fire, same;
    bit [1:0] ss;
    sb = m_bd[1]; ss = m_sd[1];
    m_bd[1] = m_bd[0]; m_bd[0] = p;
    m_sd[1] = m_sd[0]; m_sd[0] = sel;
    l = m_lvl; seen_o = m_seen; pw_o = m_pw; pw_n = pw_o; fire = 1'b0;
`ifdef AUTO_OFF_EN
    if (pw_o && m_mode == 2'b00) begin
      m_idle++;
      fire = (m_idle == int'(IDLE) - 1);
    end else begin
      m_idle = 0;
    end
`endif
    if (l && !m_need && pw_o) begin
      pw_n = 1'b0; m_need = 1'b1; m_held = 0;
    end else if (fire) begin
      pw_n = 1'b0;
    end else if (!l) begin
      m_held = 0;
      if (seen_o) m_need = 1'b0;
    end else if (!m_need && !pw_o) begin
      m_held++;
      if (m_held == int'(LP)) begin
        pw_n = 1'b1; m_need = 1'b1; m_held = 0;
      end
    end
    if (pw_o && pw_n) begin
      m_mc = (ss != m_mode); m_mode = ss;
    end else begin
      m_mc = 1'b0; m_mode = 2'b00;
    end
    m_onp = !pw_o && pw_n;
    m_offp = pw_o && !pw_n;
    m_pw = pw_n;
    m_win.push_back(sb);
    if (m_win.size() > DB) void'(m_win.pop_front());
    if (m_win.size() == DB) begin
      same = 1'b1;
      foreach (m_win[i]) if (m_win[i] != m_win[0]) same = 1'b0;
      if (same && m_win[0] != m_lvl) m_lvl = m_win[0];
      if (same && !m_win[0]) m_seen = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge(power_btn, mode_selection);
    #1;
    chk("power_state", power_state, m_pw);
    chk("mode", mode, m_mode);
    chk("power_on_pulse", power_on_pulse, m_onp);
    chk("power_off_pulse", power_off_pulse, m_offp);
    chk("mode_change", mode_change, m_mc);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_power_state", power_state, 0);
    chk("rst_mode", mode, 0);
    chk("rst_on_pulse", power_on_pulse, 0);
    chk("rst_off_pulse", power_off_pulse, 0);
    chk("rst_mode_change", mode_change, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int rise, pulses, offs;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_power_state", power_state, 0);
    chk("reset_mode", mode, 0);
    chk("reset_pulses", {power_on_pulse, power_off_pulse, mode_change}, 0);
    rst = 1'b1;
    ticks(10);

    // Long press power-on timing.
    power_btn = 1'b1; rise = 0; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (power_state && rise == 0) rise = k;
      if (power_on_pulse) pulses++;
    end
    chk("power_on_latency", rise, 26);
    chk("power_on_pulse_count", pulses, 1);
    power_btn = 1'b0;
    ticks(12);
    chk("stays_on_after_release", power_state, 1);

    // Mode latency and change pulses.
    mode_selection = 2'b01;
    ticks(2);
    chk("mode_before_latency", mode, 0);
    tick();
    chk("mode_01_latency", mode, 1);
    chk("mode_change_01", mode_change, 1);
    mode_selection = 2'b11;
    ticks(3);
    chk("mode_11_latency", mode, 3);
    repeat (6) begin
      mode_selection = 2'($urandom_range(0, 3));
      ticks($urandom_range(1, 6));
    end
    mode_selection = 2'b01;
    ticks(4);

    // Short press powers off immediately; continued hold never re-powers.
    power_btn = 1'b1; offs = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (power_off_pulse) offs++;
    end
    chk("short_press_off", power_state, 0);
    chk("mode_forced_00", mode, 0);
    chk("off_pulse_count", offs, 1);
    ticks(100);
    chk("hold_no_repower", power_state, 0);
    power_btn = 1'b0;
    ticks(12);

    // Too-short hold, then sub-debounce glitches.
    power_btn = 1'b1; pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (k == 10) power_btn = 1'b0;
      tick();
      if (power_on_pulse || power_off_pulse) pulses++;
    end
    chk("short_hold_no_power", power_state, 0);
    chk("short_hold_no_pulses", pulses, 0);
    repeat (5) begin
      power_btn = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        tick();
        chk("glitch_db_level", dut.db_level, m_lvl);
      end
      power_btn = 1'b0;
      repeat ($urandom_range(2, 5)) begin
        tick();
        chk("glitch_db_level", dut.db_level, m_lvl);
      end
    end
    ticks(6);
    chk("glitch_level_low", dut.db_level, 0);
    chk("glitch_no_power", power_state, 0);

    // Hold far past power-on: stays on until release and a new press.
    mode_selection = 2'b01; power_btn = 1'b1; offs = 0;
    for (int k = 0; k < 130; k++) begin
      tick();
      if (power_off_pulse) offs++;
    end
    chk("long_hold_stays_on", power_state, 1);
    chk("long_hold_no_off_pulse", offs, 0);
    power_btn = 1'b0;
    ticks(12);
    power_btn = 1'b1;
    ticks(10);
    chk("repress_off", power_state, 0);
    power_btn = 1'b0;
    ticks(12);

    // Reset mid-arming with the button still held.
    power_btn = 1'b1;
    ticks(22);
    async_reset();
    ticks(60);
    chk("held_through_reset_no_power", power_state, 0);
    power_btn = 1'b0;
    ticks(12);
    power_btn = 1'b1;
    ticks(30);
    chk("repress_after_reset_on", power_state, 1);
    power_btn = 1'b0;
    mode_selection = 2'b11;
    ticks(10);
    chk("powered_mode_11", mode, 3);
    async_reset();
    mode_selection = 2'b01;
    ticks(10);

    // Random button and mode activity.
    repeat (14) begin
      power_btn = 1'($urandom_range(0, 1));
      mode_selection = 2'($urandom_range(0, 3));
      ticks($urandom_range(1, 40));
    end
    power_btn = 1'b0;
    ticks(12);

`ifdef AUTO_OFF_EN
    async_reset();
    ticks(10);
    mode_selection = 2'b00; power_btn = 1'b1;
    ticks(30);
    power_btn = 1'b0; offs = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (power_off_pulse) offs++;
    end
    chk("auto_off_pulse", offs, 1);
    chk("auto_off_state", power_state, 0);
    mode_selection = 2'b01; power_btn = 1'b1;
    ticks(30);
    power_btn = 1'b0;
    ticks(80);
    chk("no_auto_off_mode01", power_state, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
